// File: rtl/encoder_pkg.sv
// Shared types and constants for the one-hot mask encoder front end.
package encoder_pkg;

   localparam int          SRC_ID_W       = 1;
   localparam int          MASK_BYTES     = 8;
   localparam logic [63:0] IDENTITY_MASKS = 64'h8040201008040201;

   // Index of one byte in the 64-bit mask table.
   typedef logic [2:0]          mask_idx_t;
   // Source identifier carried alongside each beat.
   typedef logic [SRC_ID_W-1:0] src_id_t;

endpackage : encoder_pkg

// File: rtl/encoder_ctrl_encoder.sv
// One-hot mask encoder datapath: registered lookup of the mask byte chosen by
// the highest set bit of the select byte. A zero select encodes to 0x00.
module encoder_ctrl_encoder
   import encoder_pkg::*;
(
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        i_valid,
   input  logic [7:0]  i_data,
   input  logic [63:0] i_masks,
   output logic        o_valid,
   output logic [7:0]  o_data
);

   logic [7:0] w_enc;
   logic       r_valid;
   logic [7:0] r_data;

   // Priority lookup: later (higher) set bits override earlier ones.
   always_comb begin
      w_enc = 8'h00;
      for (int i = 0; i < MASK_BYTES; i++) begin
         if (i_data[i]) begin
            w_enc = i_masks[8*i +: 8];
         end
      end
   end

   // Output register; cleared by reset so nothing stale leaves after a reset.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_valid <= 1'b0;
         r_data  <= 8'h00;
      end else begin
         r_valid <= i_valid;
         r_data  <= w_enc;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;

endmodule : encoder_ctrl_encoder

// File: rtl/encoder_ctrl.sv
// Front-end controller for the mask encoder: round-robin arbitration of two
// byte streams, shadow/active mask table with atomic commit, source tagging.
//
// Handshake: a source beat transfers in the cycle where sX_axis_tvalid and
// sX_axis_tready are both 1. tready is a combinational grant that may depend
// on tvalid; it is held low during reset and in every cycle cfg_commit is 1,
// so no beat is accepted while the table is being swapped. The output side
// has no ready: m_axis_tvalid marks a beat for exactly one cycle.
module encoder_ctrl
   import encoder_pkg::*;
#(
   parameter logic [63:0] RESET_MASKS = IDENTITY_MASKS,
   parameter int          CNT_W       = 16
) (
   input  logic             aclk,
   input  logic             aresetn,
   input  logic             s0_axis_tvalid,
   output logic             s0_axis_tready,
   input  logic [7:0]       s0_axis_tdata,
   input  logic             s1_axis_tvalid,
   output logic             s1_axis_tready,
   input  logic [7:0]       s1_axis_tdata,
   input  logic             cfg_wr,
   input  logic [2:0]       cfg_addr,
   input  logic [7:0]       cfg_wdata,
   input  logic             cfg_commit,
   output logic             m_axis_tvalid,
   output logic [7:0]       m_axis_tdata,
   output logic             m_axis_tid,
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // Grant vector {g1, g0}; when both request, the one not served last wins.
   function automatic logic [1:0] rr_grant(input logic en, input logic v0,
                                           input logic v1, input logic last);
      logic [1:0] g;
      g = 2'b00;
      if (en) begin
         if (v0 && v1) begin
            g = last ? 2'b01 : 2'b10;
         end else begin
            g = {v1, v0};
         end
      end
      return g;
   endfunction

   logic [63:0]      r_active;
   logic [63:0]      r_shadow;
   logic             r_rr_last;
   logic [CNT_W-1:0] r_cnt0;
   logic [CNT_W-1:0] r_cnt1;
   logic             r_iss_valid;
   logic [7:0]       r_iss_data;
   src_id_t          r_iss_id;
   src_id_t          r_tid;

   logic [1:0]       w_gnt;
   logic             w_acc;
   src_id_t          w_gnt_id;
   logic [7:0]       w_gnt_data;
   mask_idx_t        w_cfg_idx;
   logic [63:0]      w_shadow_nxt;

   // Arbitration: grants only outside reset and outside a commit cycle.
   always_comb begin
      w_gnt      = rr_grant(aresetn & ~cfg_commit, s0_axis_tvalid,
                            s1_axis_tvalid, r_rr_last);
      w_acc      = w_gnt[0] | w_gnt[1];
      w_gnt_id   = w_gnt[1];
      w_gnt_data = w_gnt[1] ? s1_axis_tdata :
                   w_gnt[0] ? s0_axis_tdata : 8'h00;
   end

   assign s0_axis_tready = w_gnt[0];
   assign s1_axis_tready = w_gnt[1];
   assign w_cfg_idx      = cfg_addr;

   // Shadow table including this cycle's write, so a same-cycle commit sees it.
   always_comb begin
      w_shadow_nxt = r_shadow;
      if (cfg_wr) begin
         w_shadow_nxt[{w_cfg_idx, 3'b000} +: 8] = cfg_wdata;
      end
   end

   // Mask tables: shadow takes writes, active is swapped only on commit.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_shadow <= RESET_MASKS;
         r_active <= RESET_MASKS;
      end else begin
         r_shadow <= w_shadow_nxt;
         if (cfg_commit) begin
            r_active <= w_shadow_nxt;
         end
      end
   end

   // Round-robin history and saturating per-source beat counters.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_rr_last <= 1'b1;
         r_cnt0    <= '0;
         r_cnt1    <= '0;
      end else begin
         if (w_acc) begin
            r_rr_last <= w_gnt_id;
         end
         if (w_gnt[0] && (r_cnt0 != '1)) begin
            r_cnt0 <= r_cnt0 + CNT_ONE;
         end
         if (w_gnt[1] && (r_cnt1 != '1)) begin
            r_cnt1 <= r_cnt1 + CNT_ONE;
         end
      end
   end

   // Issue stage feeding the encoder, plus the ID delay matching its register.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_iss_valid <= 1'b0;
         r_iss_data  <= 8'h00;
         r_iss_id    <= '0;
         r_tid       <= '0;
      end else begin
         r_iss_valid <= w_acc;
         r_iss_data  <= w_gnt_data;
         r_iss_id    <= w_gnt_id;
         r_tid       <= r_iss_id;
      end
   end

   encoder_ctrl_encoder u_encoder (
      .aclk    (aclk),
      .aresetn (aresetn),
      .i_valid (r_iss_valid),
      .i_data  (r_iss_data),
      .i_masks (r_active),
      .o_valid (m_axis_tvalid),
      .o_data  (m_axis_tdata)
   );

   assign m_axis_tid = r_tid;
   assign cnt0       = r_cnt0;
   assign cnt1       = r_cnt1;

endmodule : encoder_ctrl

// File: tb/tb_encoder_ctrl.sv
// Bench for encoder_ctrl: directed scenarios plus random traffic, checked
// cycle by cycle against a transaction-level model of the controller.
module tb_encoder_ctrl;

   localparam int          CNT_W     = 10;
   localparam int          CNT_MAX   = (1 << CNT_W) - 1;
   localparam logic [63:0] RST_MASKS = 64'h8040201008040201;

   // ---------------- clock / reset / DUT ----------------
   logic             aclk = 1'b0;
   logic             aresetn;
   logic             s0_v, s0_r, s1_v, s1_r;
   logic [7:0]       s0_d, s1_d;
   logic             cfg_wr, cfg_commit;
   logic [2:0]       cfg_addr;
   logic [7:0]       cfg_wdata;
   logic             m_v, m_tid;
   logic [7:0]       m_d;
   logic [CNT_W-1:0] cnt0, cnt1;

   always #5 aclk = ~aclk;

   encoder_ctrl #(.RESET_MASKS(RST_MASKS), .CNT_W(CNT_W)) dut (
      .aclk           (aclk),
      .aresetn        (aresetn),
      .s0_axis_tvalid (s0_v),
      .s0_axis_tready (s0_r),
      .s0_axis_tdata  (s0_d),
      .s1_axis_tvalid (s1_v),
      .s1_axis_tready (s1_r),
      .s1_axis_tdata  (s1_d),
      .cfg_wr         (cfg_wr),
      .cfg_addr       (cfg_addr),
      .cfg_wdata      (cfg_wdata),
      .cfg_commit     (cfg_commit),
      .m_axis_tvalid  (m_v),
      .m_axis_tdata   (m_d),
      .m_axis_tid     (m_tid),
      .cnt0           (cnt0),
      .cnt1           (cnt1)
   );

   // ---------------- scoreboard / model state ----------------
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [63:0] m_active, m_shadow;
   logic        m_rr;
   int          m_cnt0, m_cnt1;
   logic [9:0]  exp_q[$];       // {valid, id, data}, one entry per cycle
   logic        last_g0, last_g1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Mask byte for the highest set bit; zero select gives zero.
   function automatic logic [7:0] ref_encode(input logic [63:0] tbl, input logic [7:0] d);
      int hi;
      if (d == 8'h00) return 8'h00;
      hi = $clog2(int'(d) + 1) - 1;
      return tbl[8*hi +: 8];
   endfunction

   // One clock cycle: check grants mid-cycle, advance model at the edge,
   // then check the registered outputs just after the edge.
   task automatic step();
      logic       g0, g1;
      logic [9:0] ent, outexp;
      @(negedge aclk);
      g0 = 1'b0;
      g1 = 1'b0;
      if (aresetn && !cfg_commit) begin
         if (s0_v && s1_v) begin
            if (m_rr) g0 = 1'b1; else g1 = 1'b1;
         end else if (s0_v) begin
            g0 = 1'b1;
         end else if (s1_v) begin
            g1 = 1'b1;
         end
      end
      chk("s0_tready", 32'(s0_r), 32'(g0));
      chk("s1_tready", 32'(s1_r), 32'(g1));
      last_g0 = g0;
      last_g1 = g1;
      @(posedge aclk);
      #1;
      if (!aresetn) begin
         m_active = RST_MASKS;
         m_shadow = RST_MASKS;
         m_rr     = 1'b1;
         m_cnt0   = 0;
         m_cnt1   = 0;
         exp_q.delete();
         exp_q.push_back(10'h000);
         outexp   = 10'h000;
      end else begin
         ent = 10'h000;
         if (g0) begin
            ent  = {1'b1, 1'b0, ref_encode(m_active, s0_d)};
            m_rr = 1'b0;
            if (m_cnt0 < CNT_MAX) m_cnt0++;
         end
         if (g1) begin
            ent  = {1'b1, 1'b1, ref_encode(m_active, s1_d)};
            m_rr = 1'b1;
            if (m_cnt1 < CNT_MAX) m_cnt1++;
         end
         if (cfg_wr) m_shadow[8*int'(cfg_addr) +: 8] = cfg_wdata;
         if (cfg_commit) m_active = m_shadow;
         exp_q.push_back(ent);
         outexp = exp_q.pop_front();
      end
      chk("m_tvalid", 32'(m_v), 32'(outexp[9]));
      chk("m_tdata", 32'(m_d), 32'(outexp[7:0]));
      if (outexp[9]) chk("m_tid", 32'(m_tid), 32'(outexp[8]));
      chk("cnt0", 32'(cnt0), 32'(m_cnt0));
      chk("cnt1", 32'(cnt1), 32'(m_cnt1));
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input logic v0, input logic [7:0] d0, input logic v1,
                        input logic [7:0] d1, input logic wr, input logic [2:0] a,
                        input logic [7:0] wd, input logic cm, input logic rn);
      s0_v = v0; s0_d = d0; s1_v = v1; s1_d = d1;
      cfg_wr = wr; cfg_addr = a; cfg_wdata = wd; cfg_commit = cm; aresetn = rn;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         drive(0, 8'h00, 0, 8'h00, 0, 3'd0, 8'h00, 0, 1);
         step();
      end
   endtask

   task automatic do_reset();
      drive(0, 8'h00, 0, 8'h00, 0, 3'd0, 8'h00, 0, 0);
      step();
      step();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic       pv0, pv1;
      logic [7:0] pd0, pd1;
      drive(0, 8'h00, 0, 8'h00, 0, 3'd0, 8'h00, 0, 0);
      last_g0 = 1'b0;
      last_g1 = 1'b0;
      do_reset();

      // single beat from s0
      drive(1, 8'h04, 0, 8'h00, 0, 3'd0, 8'h00, 0, 1);
      step();
      idle(3);

      // both sources streaming: strict alternation
      for (int i = 0; i < 12; i++) begin
         drive(1, 8'h01, 1, 8'h80, 0, 3'd0, 8'h00, 0, 1);
         step();
      end
      idle(3);

      // shadow write has no effect until commit
      drive(0, 8'h00, 0, 8'h00, 1, 3'd2, 8'hA5, 0, 1); step();
      drive(1, 8'h04, 0, 8'h00, 0, 3'd0, 8'h00, 0, 1); step();
      idle(3);
      drive(0, 8'h00, 0, 8'h00, 0, 3'd0, 8'h00, 1, 1); step();
      drive(1, 8'h04, 0, 8'h00, 0, 3'd0, 8'h00, 0, 1); step();
      idle(3);

      // s0 streaming across commits, including write+commit in one cycle
      for (int i = 0; i < 14; i++) begin
         drive(1, (i % 2 == 0) ? 8'h02 : 8'h01, 0, 8'h00,
               (i == 3) || (i == 9), (i == 3) ? 3'd1 : 3'd0,
               (i == 3) ? 8'h3C : 8'h77, (i == 6) || (i == 9) || (i == 10), 1);
         step();
      end
      idle(3);

      // reset with beats in flight
      drive(1, 8'h80, 1, 8'h01, 0, 3'd0, 8'h00, 0, 1); step();
      drive(1, 8'h80, 1, 8'h01, 0, 3'd0, 8'h00, 0, 1); step();
      drive(1, 8'h80, 1, 8'h01, 0, 3'd0, 8'h00, 0, 0); step();
      idle(4);

      // zero select and multi-bit select with the identity table
      drive(1, 8'h00, 0, 8'h00, 0, 3'd0, 8'h00, 0, 1); step();
      drive(1, 8'h06, 0, 8'h00, 0, 3'd0, 8'h00, 0, 1); step();
      drive(0, 8'h00, 1, 8'hFF, 0, 3'd0, 8'h00, 0, 1); step();
      idle(3);

      // random traffic; a pending beat is held stable until accepted
      pv0 = 1'b0; pv1 = 1'b0; pd0 = 8'h00; pd1 = 8'h00;
      for (int i = 0; i < 500; i++) begin
         if (!(pv0 && !last_g0)) begin
            pv0 = ($urandom_range(0, 3) != 0);
            pd0 = 8'($urandom_range(0, 255));
         end
         if (!(pv1 && !last_g1)) begin
            pv1 = ($urandom_range(0, 3) != 0);
            pd1 = 8'($urandom_range(0, 255));
         end
         drive(pv0, pd0, pv1, pd1, ($urandom_range(0, 3) == 0),
               3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
               ($urandom_range(0, 9) == 0), ($urandom_range(0, 99) != 0));
         if (!aresetn) begin
            pv0 = 1'b0;
            pv1 = 1'b0;
         end
         step();
      end
      idle(3);

      // counter saturation
      do_reset();
      for (int i = 0; i < CNT_MAX + 6; i++) begin
         drive(1, 8'($urandom_range(0, 255)), 0, 8'h00, 0, 3'd0, 8'h00, 0, 1);
         step();
      end
      idle(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_encoder_ctrl
